lp_arith_inverse: RTL

- Sequential inverse-arithmetic unit, the recovery side of the team's low-power add/sub/multiply unit.
- Given a 2*WIDTH-bit result y and the known operand b, it recovers operand a:
  - y-b for add
  - y+b for subtract
  - y/b with remainder for multiply
- Valid/ready on input and output; divide is multi-cycle restoring, one quotient bit per cycle.
- op 2'b11 is the idle/gated op: operand registers are not loaded.

---
 rtl/lp_arith_pkg.sv | 19 +
 rtl/lp_arith_inverse_if.sv | 32 +++
 rtl/lp_div_step.sv | 29 ++
 rtl/lp_arith_inverse.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lp_arith_pkg.sv
// Shared definitions for the low-power arithmetic unit and its inverse.
// Holds the op encodings (common with the forward unit) and the FSM state codes.
package lp_arith_pkg;

   typedef logic [1:0] op_t;

   // Op encodings shared with the forward add/sub/multiply unit
   localparam op_t OP_ADD  = 2'b00;
   localparam op_t OP_SUB  = 2'b01;
   localparam op_t OP_MUL  = 2'b10;
   localparam op_t OP_IDLE = 2'b11;

   // Inverse-unit FSM state codes
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/lp_arith_inverse_if.sv
// Request/response bus of the inverse-arithmetic unit.
// Request : in_valid/in_ready handshake carrying op, y (2*WIDTH) and b (WIDTH).
// Response: out_valid/out_ready handshake carrying a_out, rem_out and err.
// master = requester/consumer side, slave = the unit itself.
interface lp_arith_inverse_if
   import lp_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) ();

   logic                   in_valid;
   logic                   in_ready;
   op_t                    op;
   logic [2*WIDTH-1:0]     y;
   logic [WIDTH-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       a_out;
   logic [WIDTH-1:0]       rem_out;
   logic                   err;

   modport master (
      output in_valid, op, y, b, out_ready,
      input  in_ready, out_valid, a_out, rem_out, err
   );

   modport slave (
      input  in_valid, op, y, b, out_ready,
      output in_ready, out_valid, a_out, rem_out, err
   );

endinterface

// File: rtl/lp_div_step.sv
// One combinational restoring-division step.
// Ports: rem_i    partial remainder (WIDTH+1)
//        bit_i    next dividend bit, MSB first
//        div_i    divisor (WIDTH)
//        rem_c_o  updated partial remainder (WIDTH+1)
//        qbit_c_o quotient bit produced by this step
module lp_div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH:0]   rem_c_o,
   output logic             qbit_c_o
);

   localparam int unsigned SW = WIDTH + 2;
   localparam int unsigned RW = WIDTH + 1;

   logic [SW-1:0] shifted;
   logic          fits;

   // Shift in the next dividend bit, then trial-subtract the divisor
   assign shifted  = {rem_i, bit_i};
   assign fits     = (shifted >= SW'(div_i));
   assign qbit_c_o = fits;
   assign rem_c_o  = fits ? RW'(shifted - SW'(div_i)) : shifted[WIDTH:0];

endmodule

// File: rtl/lp_arith_inverse.sv
// Inverse-arithmetic unit: recovers operand a from forward result y and known b.
//   op 00: a = y - b      op 01: a = y + b      op 10: a = y / b, rem = y % b
//   op 11: idle, operand registers stay put, zero result.
// Ports: clk, rst (sync, active high), bus (slave side of lp_arith_inverse_if).
// Add/sub/idle/error results appear one cycle after accept; a valid divide
// spends WIDTH+1 cycles in CALC (one load cycle plus one quotient bit per cycle).
module lp_arith_inverse
   import lp_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   lp_arith_inverse_if.slave bus
);

   localparam int unsigned YW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned IW = $clog2(YW);
   localparam int unsigned QW = WIDTH - 1;
   localparam int unsigned RW = WIDTH + 1;

   state_t           state_q, state_d;
   logic [YW-1:0]    y_q, y_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [QW-1:0]    quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [YW:0]      add_diff;
   logic             add_err;
   logic [YW-1:0]    sub_sum;
   logic             sub_err;
   logic             div_err;
   logic [IW-1:0]    bit_idx;
   logic [WIDTH:0]   step_rem;
   logic             step_q;

   // Undo-add: borrow or a difference wider than WIDTH cannot be recovered
   assign add_diff = {1'b0, bus.y} - (YW+1)'(bus.b);
   assign add_err  = add_diff[YW] | (|add_diff[YW-1:WIDTH]);

   // Undo-sub: modular sum must fit in WIDTH bits
   assign sub_sum  = bus.y + YW'(bus.b);
   assign sub_err  = |sub_sum[YW-1:WIDTH];

   // Divide: zero divisor or a quotient needing more than WIDTH bits
   assign div_err  = (bus.b == '0) || (bus.y[YW-1:WIDTH] >= bus.b);

   // CALC count 1..WIDTH consumes low-half dividend bits WIDTH-1 down to 0
   assign bit_idx  = IW'(WIDTH) - IW'(cnt_q);

   lp_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i    (rem_q),
      .bit_i    (y_q[bit_idx]),
      .div_i    (b_q),
      .rem_c_o  (step_rem),
      .qbit_c_o (step_q)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      b_d         = b_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      r_d         = r_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               case (bus.op)
                  OP_ADD: begin
                     a_d         = add_err ? '0 : add_diff[WIDTH-1:0];
                     r_d         = '0;
                     err_d       = add_err;
                     out_valid_d = 1'b1;
                     state_d     = ST_DONE;
                  end
                  OP_SUB: begin
                     a_d         = sub_err ? '0 : sub_sum[WIDTH-1:0];
                     r_d         = '0;
                     err_d       = sub_err;
                     out_valid_d = 1'b1;
                     state_d     = ST_DONE;
                  end
                  OP_MUL: begin
                     if (div_err) begin
                        a_d         = '0;
                        r_d         = '0;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                     end else begin
                        y_d     = bus.y;
                        b_d     = bus.b;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                     end
                  end
                  default: begin
                     // Idle op: operand registers untouched, zero result
                     a_d         = '0;
                     r_d         = '0;
                     err_d       = 1'b0;
                     out_valid_d = 1'b1;
                     state_d     = ST_DONE;
                  end
               endcase
            end
         end

         ST_CALC: begin
            if (cnt_q == '0) begin
               // Load cycle: partial remainder starts from the high half of y
               rem_d = RW'(y_q[YW-1:WIDTH]);
               cnt_d = CW'(1);
            end else begin
               rem_d = step_rem;
               quo_d = QW'({quo_q, step_q});
               if (cnt_q == CW'(WIDTH)) begin
                  a_d         = {quo_q, step_q};
                  r_d         = step_rem[WIDTH-1:0];
                  err_d       = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         y_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         r_q         <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         b_q         <= b_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         r_q         <= r_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.a_out     = a_q;
   assign bus.rem_out   = r_q;
   assign bus.err       = err_q;

endmodule
